// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep blocks: FSM state encoding,
// settle limits and the state a new vector is entered in.
package tt_sweep_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    localparam int TT_MAX_SETTLE = 15;

    // With no settle time a fresh vector is sampled on the very next edge.
    function automatic tt_state_e tt_vec_entry_state(input int settle);
        if (settle == 0) begin
            return ST_SAMPLE;
        end else begin
            return ST_SETTLE;
        end
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// 4-bit load/decrement timer; expired_o is high while the count sits at zero.
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       expired_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: load wins over decrement, and the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 4'd0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector of a small combinational DUT, samples its output
// after a settle delay and tallies mismatches against a golden truth table.
module tt_sweep_checker
    import tt_sweep_checker_pkg::*;
#(
    parameter int                    N_IN     = 4,
    parameter logic [(2**N_IN)-1:0]  EXPECTED = '0,
    parameter int                    SETTLE   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            f_in,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_seen,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);
    localparam logic [3:0]      SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam tt_state_e       VEC_ENTRY   = tt_vec_entry_state(SETTLE);

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_count_q, err_count_d;
    logic            fail_seen_q, fail_seen_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;

    logic timer_load_s;
    logic timer_dec_s;
    logic timer_expired_s;
    logic mismatch_s;

    tt_settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load_s),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (timer_dec_s),
        .expired_o  (timer_expired_s)
    );

    assign mismatch_s = (f_in != EXPECTED[vec_q]);

    // Next-state and next-result logic for the sweep FSM.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = VEC_ENTRY;
                    vec_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                    timer_load_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if (timer_expired_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_s) begin
                    err_count_d = err_count_q + ERR_ONE;
                    if (!fail_seen_q) begin
                        fail_seen_d  = 1'b1;
                        first_fail_d = vec_q;
                    end else begin
                        fail_seen_d  = fail_seen_q;
                    end
                end else begin
                    err_count_d = err_count_q;
                end
                // Last vector: results settle on the same edge as done.
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_q == '0) && !mismatch_s;
                end else begin
                    state_d      = VEC_ENTRY;
                    vec_d        = vec_q + VEC_ONE;
                    timer_load_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

endmodule
